serial_add16: RTL and testbench

SERIAL_ADD16 -- requirements
Module: serial_add16

---
 rtl/addsub_pkg.sv | 12 +
 rtl/bocong.sv | 23 ++
 rtl/serial_add16.sv | 100 ++++++++++
 tb/tb_serial_add16.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package addsub_pkg;

  localparam int unsigned NibW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/bocong.sv
// Combinational 4-bit ripple-carry adder used for each nibble pass.
module bocong
  import addsub_pkg::*;
(
  input  logic [NibW-1:0] a,
  input  logic [NibW-1:0] b,
  input  logic            cin,
  output logic            cout,
  output logic [NibW-1:0] s
);

  logic [NibW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NibW; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NibW];

endmodule

// File: rtl/serial_add16.sv
// Nibble-serial adder: latches a, b, cin, then adds one nibble per cycle through a single
// 4-bit adder with a registered carry, presenting sum/cout under a valid/ready handshake.
module serial_add16
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / NibW;
  localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic            cout_q;
  logic            out_valid_q;

  logic [NibW-1:0] nib_a;
  logic [NibW-1:0] nib_b;
  logic [NibW-1:0] nib_s;
  logic            nib_c;

  assign nib_a = a_q[int'(idx_q) * NibW +: NibW];
  assign nib_b = b_q[int'(idx_q) * NibW +: NibW];

  bocong u_nib_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .cout (nib_c),
    .s    (nib_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[int'(idx_q) * NibW +: NibW] <= nib_s;
          carry_q <= nib_c;
          idx_q   <= idx_q + IdxW'(1);
          // cout is only updated with the final carry so it stays stable outside DONE too
          if (idx_q == LastIdx) begin
            cout_q      <= nib_c;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add16.sv
// Randomised and directed checks of serial_add16 against an arithmetic reference model.
module tb_serial_add16;

  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int unsigned hs_cyc[$];
  logic [W:0]  res_q[$];

  serial_add16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) hs_cyc.push_back(cyc);
    if (out_valid && out_ready) res_q.push_back({cout, sum});
  end

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + (W + 1)'(c);
  endfunction

  // Drive one operand set and wait for out_valid; lat = edges from handshake to out_valid.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL txn_in_ready: got %b want 1", in_ready);
    end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (sum !== '0) begin n_fail++; $display("FAIL rst_sum: got %h want 0", sum); end
    if (cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b want 0", cout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4] = '{16'h0005, 16'hFFFF, 16'h000D, 16'hFFFF};
    logic [W-1:0] vb[4] = '{16'h0000, 16'h0001, 16'h0009, 16'hFFFF};
    logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] es[4] = '{16'h0005, 16'h0000, 16'h0016, 16'hFFFF};
    logic         ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_txn(va[i], vb[i], vc[i], lat);
      n_cmp += 5;
      if (lat != NIB) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NIB); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
      if (sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, sum, es[i]); end
      if (cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout: got %b want %b", i, cout, ec[i]); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL dir%0d_busy: got %b want 1", i, busy); end
      accept();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ta, tb;
    logic tc;
    logic [W:0] exp;
    int lat;
    ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
    exp = model(ta, tb, tc);
    do_txn(ta, tb, tc, lat);
    repeat (3) begin
      @(negedge clk);
      n_cmp += 2;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
      if ({cout, sum} !== exp) begin n_fail++; $display("FAIL bp_hold_result: got %h want %h", {cout, sum}, exp); end
    end
    accept();
    n_cmp += 4;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_rel_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rel_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_rel_busy: got %b want 0", busy); end
    if ({cout, sum} !== exp) begin n_fail++; $display("FAIL bp_rel_keep: got %h want %h", {cout, sum}, exp); end
  endtask

  task automatic test_ignore_in_run();
    logic [W-1:0] ta, tb;
    logic tc;
    logic [W:0] exp;
    int lat;
    ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
    exp = model(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    a = ~ta; b = ~tb ^ 16'h1234; cin = ~tc;
    lat = 0;
    repeat (2) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_in_ready: got %b want 0", in_ready); end
      @(negedge clk);
      lat++;
      a = W'($urandom); b = W'($urandom);
    end
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp += 2;
    if (lat != NIB) begin n_fail++; $display("FAIL ign_latency: got %0d want %0d", lat, NIB); end
    if ({cout, sum} !== exp) begin n_fail++; $display("FAIL ign_result: got %h want %h", {cout, sum}, exp); end
    accept();
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] ta, tb;
    logic tc;
    logic [W:0] exp;
    int lat;
    @(negedge clk);
    a = W'($urandom) | 16'h0003; b = 16'h0000; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    if (sum !== '0) begin n_fail++; $display("FAIL abort_sum: got %h want 0", sum); end
    if (cout !== 1'b0) begin n_fail++; $display("FAIL abort_cout: got %b want 0", cout); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
    exp = model(ta, tb, tc);
    @(negedge clk);
    rst = 1'b0;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL post_rst_accept: got busy %b want 1", busy); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp += 2;
    if (lat != NIB) begin n_fail++; $display("FAIL post_rst_latency: got %0d want %0d", lat, NIB); end
    if ({cout, sum} !== exp) begin n_fail++; $display("FAIL post_rst_result: got %h want %h", {cout, sum}, exp); end
    accept();
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tb;
    logic tc;
    logic [W:0] exp;
    int lat;
    for (int i = 0; i < 20; i++) begin
      ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
      if (i == 0) begin ta = '1; tb = '1; tc = 1'b1; end
      exp = model(ta, tb, tc);
      do_txn(ta, tb, tc, lat);
      n_cmp += 2;
      if (lat != NIB) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, NIB); end
      if ({cout, sum} !== exp) begin n_fail++; $display("FAIL rnd%0d_result: got %h want %h", i, {cout, sum}, exp); end
      repeat ($urandom_range(2)) begin
        @(negedge clk);
        n_cmp++;
        if ({out_valid, cout, sum} !== {1'b1, exp}) begin
          n_fail++;
          $display("FAIL rnd%0d_hold: got %h want %h", i, {out_valid, cout, sum}, {1'b1, exp});
        end
      end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[4], ob[4];
    logic oc[4];
    int n, g;
    hs_cyc.delete();
    res_q.delete();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
      a = oa[i]; b = ob[i]; cin = oc[i]; in_valid = 1'b1;
      n = hs_cyc.size();
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (hs_cyc.size() == n && g < 20);
    end
    in_valid = 1'b0;
    g = 0;
    while (res_q.size() < 4 && g < 40) begin
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    n_cmp += 2;
    if (res_q.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", res_q.size()); end
    if (hs_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_hs_count: got %0d want 4", hs_cyc.size()); end
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      n_cmp++;
      if (res_q[i] !== model(oa[i], ob[i], oc[i])) begin
        n_fail++;
        $display("FAIL b2b%0d_result: got %h want %h", i, res_q[i], model(oa[i], ob[i], oc[i]));
      end
    end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      n_cmp++;
      if (hs_cyc[i] - hs_cyc[i-1] != NIB + 2) begin
        n_fail++;
        $display("FAIL b2b%0d_interval: got %0d want %0d", i, hs_cyc[i] - hs_cyc[i-1], NIB + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_run();
    test_reset_abort();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
